lsu: RTL and testbench

- Load/store unit between execute and RAM; consumes ram_size_e/address/data from decode-execute, drives a single-outstanding word-addressed memory bus.
- Returns load data to writeback (WB_RAM path).
- Multi-cycle: request/grant/response handshake to memory, alignment checking, byte-lane steering, sign/zero extension, bus timeout.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu.sv | 175 +++++++++++++++++
 tb/tb_lsu.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit and its byte-lane aligner.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } ram_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_e;

  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering, load extension and alignment check for
// one word-addressed access; shared with the future cache path.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] rdata_shift;

  assign rdata_shift = rdata >> {offset, 3'b000};

  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = rdata_shift;
    misaligned = 1'b0;
    case (size)
      BYTE: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = is_unsigned ? {24'h000000, rdata_shift[7:0]}
                                 : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      end
      HALF_WORD: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {16'h0000, rdata_shift[15:0]}
                                 : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
        misaligned = offset[0];
      end
      WORD: begin
        be         = 4'b1111;
        misaligned = (offset != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding request/grant/response bus master with
// alignment checking, lane steering, load extension and a bus timeout.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic        req_unsigned,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  lsu_state_e  state;
  lsu_state_e  state_nxt;

  logic        store_q;
  logic        unsigned_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] tmo_cnt;
  logic        tmo_expired;

  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_nxt;
  logic        rsp_err_nxt;

  logic        accept;
  logic        in_idle;
  logic [1:0]  al_size;
  logic [1:0]  al_offset;
  logic [3:0]  al_be;
  logic [31:0] al_wdata_lane;
  logic [31:0] al_rdata_ext;
  logic        al_misaligned;

  assign in_idle = (state == LSU_IDLE);
  assign accept  = in_idle && req_valid;

  // In IDLE the aligner vets the incoming request; afterwards it serves the latched one.
  assign al_size   = in_idle ? req_size      : size_q;
  assign al_offset = in_idle ? req_addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .size        (al_size),
    .offset      (al_offset),
    .is_unsigned (unsigned_q),
    .wdata       (wdata_q),
    .rdata       (mem_rdata),
    .be          (al_be),
    .wdata_lane  (al_wdata_lane),
    .rdata_ext   (al_rdata_ext),
    .misaligned  (al_misaligned)
  );

  // The counter includes the current cycle, so expiry fires on the last allowed one.
  assign tmo_expired = (TIMEOUT_CYCLES != 0) && (tmo_cnt >= TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LSU_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else if (accept) begin
      store_q    <= req_store;
      unsigned_q <= req_unsigned;
      size_q     <= req_size;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 32'h0;
    end else if (accept && !al_misaligned) begin
      tmo_cnt <= 32'h0;
    end else if ((state == LSU_REQ) || (state == LSU_WAIT)) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_rdata_q <= rsp_rdata_nxt;
      rsp_err_q   <= rsp_err_nxt;
    end
  end

  // Completion from the bus takes priority over a timeout expiring in the same cycle.
  always_comb begin
    state_nxt     = state;
    rsp_rdata_nxt = 32'h0;
    rsp_err_nxt   = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (req_valid) begin
          if (al_misaligned) begin
            state_nxt   = LSU_RESP;
            rsp_err_nxt = 1'b1;
          end else begin
            state_nxt = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (mem_gnt) begin
          state_nxt = store_q ? LSU_RESP : LSU_WAIT;
        end else if (tmo_expired) begin
          state_nxt   = LSU_RESP;
          rsp_err_nxt = 1'b1;
        end
      end
      LSU_WAIT: begin
        if (mem_rvalid) begin
          state_nxt     = LSU_RESP;
          rsp_rdata_nxt = al_rdata_ext;
        end else if (tmo_expired) begin
          state_nxt   = LSU_RESP;
          rsp_err_nxt = 1'b1;
        end
      end
      LSU_RESP: begin
        state_nxt = LSU_IDLE;
      end
      default: begin
        state_nxt = LSU_IDLE;
      end
    endcase
  end

  assign req_ready = in_idle;
  assign mem_req   = (state == LSU_REQ);
  assign mem_we    = mem_req && store_q;
  assign mem_addr  = mem_req ? word_addr(addr_q) : 32'h0;
  assign mem_be    = mem_req ? al_be : 4'b0000;
  assign mem_wdata = (mem_req && store_q) ? al_wdata_lane : 32'h0;

  assign rsp_valid = (state == LSU_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expectations are queued at issue time and
// popped on the response cycle; bus timing is driven cycle-exactly.
module tb_lsu;
  import lsu_pkg::*;

  localparam int unsigned TO = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic        req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_unsigned (req_unsigned),
    .req_size     (req_size),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   rsp_pulses = 0;

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_pulses++;

  localparam int NST = 5;
  localparam logic [1:0]  ST_SIZE [NST] = '{BYTE, HALF_WORD, WORD, BYTE, HALF_WORD};
  localparam logic [31:0] ST_ADDR [NST] = '{32'h1003, 32'h1002, 32'h1004, 32'h1000, 32'h2000};
  localparam logic [31:0] ST_DATA [NST] = '{32'hDEADBEEF, 32'h0000ABCD, 32'h11223344, 32'h11223344, 32'hFFFF5A5A};
  localparam logic [31:0] ST_WADR [NST] = '{32'h1000, 32'h1000, 32'h1004, 32'h1000, 32'h2000};
  localparam logic [3:0]  ST_BE   [NST] = '{4'b1000, 4'b1100, 4'b1111, 4'b0001, 4'b0011};
  localparam logic [31:0] ST_LANE [NST] = '{32'hEFEFEFEF, 32'hABCDABCD, 32'h11223344, 32'h44444444, 32'h5A5A5A5A};

  localparam int NLD = 8;
  localparam logic [1:0]  LD_SIZE [NLD] = '{BYTE, BYTE, HALF_WORD, HALF_WORD, BYTE, WORD, HALF_WORD, BYTE};
  localparam logic        LD_UNS  [NLD] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [31:0] LD_ADDR [NLD] = '{32'h2002, 32'h2002, 32'h2002, 32'h2002, 32'h2001, 32'h2000, 32'h2000, 32'h2003};
  localparam logic [31:0] LD_RAW  [NLD] = '{32'h0080FF00, 32'h0080FF00, 32'h0080FF00, 32'h80010000,
                                             32'h00007F00, 32'hCAFEF00D, 32'h1234F00D, 32'hA5000000};
  localparam logic [3:0]  LD_BE   [NLD] = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b0010, 4'b1111, 4'b0011, 4'b1000};
  localparam logic [31:0] LD_EXP  [NLD] = '{32'hFFFFFF80, 32'h00000080, 32'h00000080, 32'hFFFF8001,
                                             32'h0000007F, 32'hCAFEF00D, 32'hFFFFF00D, 32'h000000A5};

  localparam int NMA = 6;
  localparam logic        MA_ST   [NMA] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic        MA_UNS  [NMA] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [1:0]  MA_SIZE [NMA] = '{HALF_WORD, SIZE_ILLEGAL, WORD, WORD, HALF_WORD, HALF_WORD};
  localparam logic [31:0] MA_ADDR [NMA] = '{32'h3001, 32'h3000, 32'h3002, 32'h3001, 32'h3003, 32'h3003};

  // Presents one request for a single accepting edge, then scrambles the fields.
  task automatic issue(input logic st, input logic uns, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_store    = st;
    req_unsigned = uns;
    req_size     = sz;
    req_addr     = a;
    req_wdata    = wd;
    @(negedge clk);
    req_valid    = 1'b0;
    req_store    = ~st;
    req_unsigned = ~uns;
    req_size     = 2'b11;
    req_addr     = 32'hFFFF_FFFF;
    req_wdata    = 32'h0BAD_0BAD;
  endtask

  task automatic test_reset();
    int p0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst mem_req got=%b exp=0", mem_req); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({rsp_rdata, rsp_err} !== 33'h0) begin failures++; $display("[TB] FAIL rst rsp got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== 69'h0) begin failures++; $display("[TB] FAIL rst mem_bus got we=%b be=%b a=%h d=%h exp=0", mem_we, mem_be, mem_addr, mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst req_ready got=%b exp=1", req_ready); end

    p0 = rsp_pulses;
    issue(1'b0, 1'b0, WORD, 32'h40, 32'h0);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL rst_req mem_req got=%b exp=1", mem_req); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_async mem_req got=%b exp=0", mem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 1'b0, WORD, 32'h44, 32'h0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1 rst_n = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait mem_req got=%b exp=0", mem_req); end
    mem_rvalid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rsp_pulses !== p0) begin failures++; $display("[TB] FAIL rst_wait rsp_pulses got=%0d exp=%0d", rsp_pulses, p0); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_store();
    exp_t e;
    for (int i = 0; i < NST; i++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b0});
      issue(1'b1, 1'b0, ST_SIZE[i], ST_ADDR[i], ST_DATA[i]);
      checks++; if ({mem_req, mem_we} !== 2'b11) begin failures++; $display("[TB] FAIL st%0d req/we got=%b exp=11", i, {mem_req, mem_we}); end
      checks++; if (mem_addr !== ST_WADR[i]) begin failures++; $display("[TB] FAIL st%0d mem_addr got=%h exp=%h", i, mem_addr, ST_WADR[i]); end
      checks++; if (mem_be !== ST_BE[i]) begin failures++; $display("[TB] FAIL st%0d mem_be got=%b exp=%b", i, mem_be, ST_BE[i]); end
      checks++; if (mem_wdata !== ST_LANE[i]) begin failures++; $display("[TB] FAIL st%0d mem_wdata got=%h exp=%h", i, mem_wdata, ST_LANE[i]); end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL st%0d rsp_valid@2 got=%b exp=1", i, rsp_valid); end
      e = sb.pop_front();
      checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin failures++; $display("[TB] FAIL st%0d rsp got=%h/%b exp=%h/%b", i, rsp_rdata, rsp_err, e.rdata, e.err); end
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_rdata, rsp_err} !== 34'h0) begin failures++; $display("[TB] FAIL st%0d after_rsp got=%b/%h/%b exp=0", i, rsp_valid, rsp_rdata, rsp_err); end
    end
  endtask

  task automatic test_load_ext();
    exp_t e;
    for (int i = 0; i < NLD; i++) begin
      sb.push_back('{rdata: LD_EXP[i], err: 1'b0});
      issue(1'b0, LD_UNS[i], LD_SIZE[i], LD_ADDR[i], 32'hFFFF_FFFF);
      checks++; if ({mem_req, mem_we} !== 2'b10) begin failures++; $display("[TB] FAIL ld%0d req/we got=%b exp=10", i, {mem_req, mem_we}); end
      checks++; if ({mem_addr, mem_be} !== {32'h2000, LD_BE[i]}) begin failures++; $display("[TB] FAIL ld%0d addr/be got=%h/%b exp=00002000/%b", i, mem_addr, mem_be, LD_BE[i]); end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      checks++; if ({mem_req, rsp_valid} !== 2'b00) begin failures++; $display("[TB] FAIL ld%0d wait req/valid got=%b exp=00", i, {mem_req, rsp_valid}); end
      mem_rvalid = 1'b1;
      mem_rdata  = LD_RAW[i];
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h5555_AAAA;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL ld%0d rsp_valid@3 got=%b exp=1", i, rsp_valid); end
      e = sb.pop_front();
      checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin failures++; $display("[TB] FAIL ld%0d rsp got=%h/%b exp=%h/%b", i, rsp_rdata, rsp_err, e.rdata, e.err); end
      @(negedge clk);
    end
  endtask

  task automatic test_misaligned();
    exp_t e;
    for (int i = 0; i < NMA; i++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b1});
      issue(MA_ST[i], MA_UNS[i], MA_SIZE[i], MA_ADDR[i], 32'hCAFEBABE);
      checks++; if ({mem_req, rsp_valid} !== 2'b01) begin failures++; $display("[TB] FAIL ma%0d req/valid@1 got=%b exp=01", i, {mem_req, rsp_valid}); end
      e = sb.pop_front();
      checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin failures++; $display("[TB] FAIL ma%0d rsp got=%h/%b exp=%h/%b", i, rsp_rdata, rsp_err, e.rdata, e.err); end
      @(negedge clk);
      checks++; if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin failures++; $display("[TB] FAIL ma%0d idle got=%b exp=001", i, {mem_req, rsp_valid, req_ready}); end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    sb.push_back('{rdata: 32'h12345678, err: 1'b0});
    issue(1'b0, 1'b0, WORD, 32'h4008, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      checks++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'b1111, 32'h4008}) begin
        failures++; $display("[TB] FAIL stall c%0d bus got=%b%b/%b/%h exp=10/1111/00004008", k, mem_req, mem_we, mem_be, mem_addr);
      end
      if (k < 6) begin
        req_valid  = 1'b1;
        req_addr   = 32'h9000 + k;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD0000 + k;
        @(negedge clk);
        req_valid  = 1'b0;
        mem_rvalid = 1'b0;
      end
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int k = 7; k <= 8; k++) begin
      checks++; if ({mem_req, rsp_valid} !== 2'b00) begin failures++; $display("[TB] FAIL stall c%0d wait got=%b exp=00", k, {mem_req, rsp_valid}); end
      @(negedge clk);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall rsp_valid got=%b exp=1", rsp_valid); end
    e = sb.pop_front();
    checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin failures++; $display("[TB] FAIL stall rsp got=%h/%b exp=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e;
    int   p0;
    // No grant at all: error on cycle TO+1.
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    issue(1'b0, 1'b0, WORD, 32'h5000, 32'h0);
    for (int c = 1; c <= int'(TO); c++) begin
      checks++; if ({mem_req, rsp_valid} !== 2'b10) begin failures++; $display("[TB] FAIL tmo_req c%0d got=%b exp=10", c, {mem_req, rsp_valid}); end
      @(negedge clk);
    end
    checks++; if ({mem_req, rsp_valid} !== 2'b01) begin failures++; $display("[TB] FAIL tmo_req expire got=%b exp=01", {mem_req, rsp_valid}); end
    e = sb.pop_front();
    checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin failures++; $display("[TB] FAIL tmo_req rsp got=%h/%b exp=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    @(negedge clk);
    p0 = rsp_pulses;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({rsp_pulses == p0, req_ready} !== 2'b11) begin failures++; $display("[TB] FAIL tmo_late pulses got=%0d exp=%0d ready=%b", rsp_pulses, p0, req_ready); end

    // Granted but no read data.
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    issue(1'b0, 1'b0, WORD, 32'h5004, 32'h0);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int c = 2; c <= int'(TO); c++) begin
      checks++; if ({mem_req, rsp_valid} !== 2'b00) begin failures++; $display("[TB] FAIL tmo_wait c%0d got=%b exp=00", c, {mem_req, rsp_valid}); end
      @(negedge clk);
    end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL tmo_wait expire rsp_valid got=%b exp=1", rsp_valid); end
    e = sb.pop_front();
    checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin failures++; $display("[TB] FAIL tmo_wait rsp got=%h/%b exp=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    @(negedge clk);

    // Grant and rvalid each land on an expired cycle and still complete.
    sb.push_back('{rdata: 32'hA1B2C3D4, err: 1'b0});
    issue(1'b0, 1'b0, WORD, 32'h5008, 32'h0);
    repeat (TO - 1) @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL tmo_tie req@%0d got=%b exp=1", TO, mem_req); end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++; if ({mem_req, rsp_valid} !== 2'b00) begin failures++; $display("[TB] FAIL tmo_tie wait got=%b exp=00", {mem_req, rsp_valid}); end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hA1B2C3D4;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL tmo_tie rsp_valid got=%b exp=1", rsp_valid); end
    e = sb.pop_front();
    checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin failures++; $display("[TB] FAIL tmo_tie rsp got=%h/%b exp=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    req_valid = 1'b1; req_store = 1'b0; req_unsigned = 1'b0;
    req_size  = HALF_WORD; req_addr = 32'h3001; req_wdata = 32'h0;
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 2'b10) begin failures++; $display("[TB] FAIL b2b c1 got=%b exp=10", {rsp_valid, req_ready}); end
    e = sb.pop_front();
    checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin failures++; $display("[TB] FAIL b2b rsp1 got=%h/%b exp=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin failures++; $display("[TB] FAIL b2b c2 got=%b exp=01", {rsp_valid, req_ready}); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b c3 rsp_valid got=%b exp=1", rsp_valid); end
    e = sb.pop_front();
    checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin failures++; $display("[TB] FAIL b2b rsp2 got=%h/%b exp=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    @(negedge clk);

    // Grant already high while idle is only taken once the request is on the bus.
    sb.push_back('{rdata: 32'h0, err: 1'b0});
    mem_gnt = 1'b1;
    issue(1'b1, 1'b0, WORD, 32'h6000, 32'h01020304);
    checks++; if ({mem_req, mem_wdata} !== {1'b1, 32'h01020304}) begin failures++; $display("[TB] FAIL b2b st bus got=%b/%h exp=1/01020304", mem_req, mem_wdata); end
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b st rsp_valid got=%b exp=1", rsp_valid); end
    e = sb.pop_front();
    checks++; if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin failures++; $display("[TB] FAIL b2b st rsp got=%h/%b exp=%h/%b", rsp_rdata, rsp_err, e.rdata, e.err); end
    @(negedge clk);
    checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL sb_drain left=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_ext();
    test_misaligned();
    test_stall();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
